letter_scheduler: RTL and testbench
===================================

# letter_scheduler

Sequences the falling-letter datapath of the typing game. Owns a fixed pool of letter slots and decides when to sample the random letter generator into a free slot. Advances every live letter once per video frame, resolves keyboard hits and bottom-edge misses, and runs the game state machine (idle / running / over). Sits between the generator, the PS/2 key decoder and the VGA renderer, which reads the slot outputs.

## Interface
- SLOTS, 4: number of concurrent letters (1..8).
- SPAWN_PERIOD, 60: frame ticks between spawn attempts (≥1).
- X_MAX, 440: row at or beyond which a letter counts as missed.
- MISS_LIMIT, 10: misses that end the game (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  one-cycle pulse; starts or restarts a game.
- gen_ch  in  8  generator letter (ASCII).
- gen_speed  in  3  generator speed, rows per frame.
- gen_y  in  10  generator column.
- key_valid  in  1  one-cycle pulse; key_ch is valid.
- key_ch  in  8  typed character (ASCII).
- state  out  2  0 = IDLE, 1 = RUN, 2 = OVER.
- slot_valid  out  SLOTS  per-slot live flag.
- slot_ch  out  8*SLOTS  per-slot letter; slot i is bits [8i+7:8i].
- slot_x  out  9*SLOTS  per-slot row.
- slot_y  out  10*SLOTS  per-slot column.
- slot_spd  out  3*SLOTS  per-slot speed.
- hit_pulse  out  1  one-cycle pulse when a letter is hit.
- miss_pulse  out  1  one-cycle pulse when one or more letters are missed.
- score  out  16  hit count, saturating at 65535.
- miss_cnt  out  8  miss count, saturating at 255.

## Operation
- FSM transitions:
  - IDLE → RUN on start.
  - RUN → OVER when the registered miss_cnt ≥ MISS_LIMIT.
  - OVER → RUN on start.
  - start while in RUN restarts the game.
- Entering RUN, from any state:
  - clear slot_valid, score, miss_cnt and the spawn counter;
  - slot data is don't-care while its valid flag is low.
- In IDLE and OVER:
  - frame_tick and key_valid are ignored;
  - slots are frozen, so OVER keeps the last field on screen.
- Spawn counter (RUN only):
  - counts frame_tick from 0 to SPAWN_PERIOD-1;
  - on the tick where it wraps to 0, a spawn attempt occurs.
- Spawn:
  - target is the lowest-index slot whose valid was 0 at the start of the cycle;
  - load ch = gen_ch, y = gen_y, x = 0, spd = gen_speed (gen_speed = 0 is loaded as 1), valid = 1;
  - no free slot: the attempt is dropped and the counter still wraps;
  - a slot freed in the same cycle is not reusable until the next cycle.
- Movement, on frame_tick in RUN:
  - each live slot gets x_new = x + spd, computed 10 bits wide;
  - if x_new ≥ X_MAX: valid cleared, the miss is counted, x is left unchanged;
  - otherwise x = x_new[8:0].
  - A slot spawned this cycle does not move this cycle.
- Key, on key_valid in RUN:
  - candidates are live slots with slot_ch == key_ch, exact 8-bit compare, no case folding;
  - the candidate with the largest x wins (lowest index on a tie);
  - the winner is cleared, hit_pulse is asserted and score += 1 (saturating);
  - no candidate: no effect.
- Simultaneous key and frame_tick:
  - the key is resolved against pre-tick contents;
  - the hit slot is cleared and not moved, so it cannot also miss;
  - other slots move normally.
- Multiple misses in one tick:
  - miss_cnt += number of misses, saturating at 255;
  - miss_pulse is a single cycle.
- Key, spawn and movement may all occur in the same cycle; each acts on disjoint slots per the rules above.

## Timing
- Reset (asynchronous, rst_n = 0):
  - state = IDLE;
  - all slot_valid, slot_ch, slot_x, slot_y, slot_spd = 0;
  - hit_pulse, miss_pulse = 0; score = 0; miss_cnt = 0; spawn counter = 0.
- All outputs are registered.
- Event in cycle t (tick, key, start) → effect visible at t+1.
- Game-over latency: miss_cnt reaching MISS_LIMIT at t+1 gives state = OVER at t+2.
  - Events in the cycle between are still processed.
- First spawn after entering RUN occurs on the SPAWN_PERIOD-th frame_tick.
- gen_* is sampled only in the spawn cycle and needs no hold afterwards.

## Test plan
- Reset then start, SPAWN_PERIOD = 3, gen_ch = 0x41, gen_speed = 2, gen_y = 100, 3 frame_ticks → slot0 valid, ch 0x41, x 0, y 100; next tick x = 2.
- Fill all 4 slots, one more spawn attempt → no change, counter wraps; clear slot 2 by key → next spawn lands in slot 2.
- Slots 0 and 1 both 'B' at x = 50 and x = 80, key_ch = 0x42 → slot1 cleared, score = 1, hit_pulse for one cycle; key 0x62 (lowercase) → no effect.
- Slot at x = 438 with speed 2, frame_tick → valid cleared, miss_cnt + 1; same setup with a matching key in the same cycle → hit, miss_cnt unchanged.
- MISS_LIMIT = 2, two slots missing on one tick → miss_cnt = 2, single miss_pulse, state = OVER two cycles after the tick; further ticks/keys do not change the slots; start → RUN, all cleared.
- Assert rst_n low mid-game with slots live → all outputs zero immediately, state IDLE; ticks ignored until start.

Source files
------------

// File: rtl/letter_scheduler.sv
// letter_scheduler: falling-letter slot pool with spawn, movement,
// key hits, bottom-edge misses and the idle/run/over game control.
module letter_scheduler #(
    parameter int SLOTS        = 4,
    parameter int SPAWN_PERIOD = 60,
    parameter int X_MAX        = 440,
    parameter int MISS_LIMIT   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic [7:0]            gen_ch,
    input  logic [2:0]            gen_speed,
    input  logic [9:0]            gen_y,
    input  logic                  key_valid,
    input  logic [7:0]            key_ch,
    output logic [1:0]            state,
    output logic [SLOTS-1:0]      slot_valid,
    output logic [8*SLOTS-1:0]    slot_ch,
    output logic [9*SLOTS-1:0]    slot_x,
    output logic [10*SLOTS-1:0]   slot_y,
    output logic [3*SLOTS-1:0]    slot_spd,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic [15:0]           score,
    output logic [7:0]            miss_cnt
);

    localparam int CW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_PERIOD - 1);
    localparam logic [9:0]    XLIM     = 10'(X_MAX);
    localparam logic [7:0]    MLIM     = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [SLOTS-1:0] valid_q, valid_n;
    logic [7:0]       ch_q  [SLOTS];
    logic [7:0]       ch_n  [SLOTS];
    logic [8:0]       x_q   [SLOTS];
    logic [8:0]       x_n   [SLOTS];
    logic [9:0]       y_q   [SLOTS];
    logic [9:0]       y_n   [SLOTS];
    logic [2:0]       spd_q [SLOTS];
    logic [2:0]       spd_n [SLOTS];
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [15:0]      score_q, score_n;
    logic [7:0]       miss_q, miss_n;
    logic             hit_q, hit_n;
    logic             mp_q, mp_n;

    logic [SLOTS-1:0] hit_oh;
    logic [SLOTS-1:0] free_oh;
    logic             key_hit;
    logic [8:0]       best_x;
    logic             spawn_go;
    logic [3:0]       nmiss;
    logic [9:0]       x_new;
    logic [8:0]       miss_sum;

    // Next game state; start always (re)enters RUN
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_n = S_RUN;
            S_RUN: begin
                if (start)
                    state_n = S_RUN;
                else if (miss_q >= MLIM)
                    state_n = S_OVER;
            end
            S_OVER:  if (start) state_n = S_RUN;
            default: state_n = S_IDLE;
        endcase
    end

    // Game state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_n;
    end

    // Key target: live matching slot lowest on screen, lowest index on ties
    always_comb begin
        hit_oh  = '0;
        key_hit = 1'b0;
        best_x  = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (key_valid && valid_q[i] && ch_q[i] == key_ch &&
                (!key_hit || x_q[i] > best_x)) begin
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                key_hit   = 1'b1;
                best_x    = x_q[i];
            end
        end
    end

    // Spawn target: lowest-index slot that is empty at cycle start
    always_comb begin
        free_oh = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    // Slot pool update: hit, move/miss and spawn act on disjoint slots
    always_comb begin
        valid_n  = valid_q;
        ch_n     = ch_q;
        x_n      = x_q;
        y_n      = y_q;
        spd_n    = spd_q;
        cnt_n    = cnt_q;
        score_n  = score_q;
        miss_n   = miss_q;
        hit_n    = 1'b0;
        mp_n     = 1'b0;
        spawn_go = 1'b0;
        nmiss    = '0;
        x_new    = '0;
        miss_sum = '0;
        if (start) begin
            valid_n = '0;
            cnt_n   = '0;
            score_n = '0;
            miss_n  = '0;
        end else if (state_q == S_RUN) begin
            if (key_hit) begin
                valid_n = valid_n & ~hit_oh;
                hit_n   = 1'b1;
                if (score_q != 16'hFFFF)
                    score_n = score_q + 16'd1;
            end
            if (frame_tick) begin
                spawn_go = (cnt_q == CNT_LAST);
                cnt_n    = spawn_go ? '0 : cnt_q + 1'b1;
                for (int i = 0; i < SLOTS; i++) begin
                    if (valid_q[i] && !hit_oh[i]) begin
                        x_new = {1'b0, x_q[i]} + {7'd0, spd_q[i]};
                        if (x_new >= XLIM) begin
                            valid_n[i] = 1'b0;
                            nmiss      = nmiss + 4'd1;
                        end else begin
                            x_n[i] = x_new[8:0];
                        end
                    end
                end
                if (nmiss != 4'd0) begin
                    mp_n     = 1'b1;
                    miss_sum = {1'b0, miss_q} + {5'd0, nmiss};
                    miss_n   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
                end
                for (int i = 0; i < SLOTS; i++) begin
                    if (spawn_go && free_oh[i]) begin
                        valid_n[i] = 1'b1;
                        ch_n[i]    = gen_ch;
                        x_n[i]     = '0;
                        y_n[i]     = gen_y;
                        spd_n[i]   = (gen_speed == 3'd0) ? 3'd1 : gen_speed;
                    end
                end
            end
        end
    end

    // Slot pool, spawn counter, tallies and event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            miss_q  <= '0;
            hit_q   <= 1'b0;
            mp_q    <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                ch_q[i]  <= '0;
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                spd_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_n;
            cnt_q   <= cnt_n;
            score_q <= score_n;
            miss_q  <= miss_n;
            hit_q   <= hit_n;
            mp_q    <= mp_n;
            for (int i = 0; i < SLOTS; i++) begin
                ch_q[i]  <= ch_n[i];
                x_q[i]   <= x_n[i];
                y_q[i]   <= y_n[i];
                spd_q[i] <= spd_n[i];
            end
        end
    end

    // Flatten slot registers onto the renderer-facing buses
    always_comb begin
        slot_ch  = '0;
        slot_x   = '0;
        slot_y   = '0;
        slot_spd = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_ch[8*i +: 8]   = ch_q[i];
            slot_x[9*i +: 9]    = x_q[i];
            slot_y[10*i +: 10]  = y_q[i];
            slot_spd[3*i +: 3]  = spd_q[i];
        end
    end

    assign state      = state_q;
    assign slot_valid = valid_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = mp_q;
    assign score      = score_q;
    assign miss_cnt   = miss_q;

endmodule

// File: tb/tb_letter_scheduler.sv
// tb_letter_scheduler: scoreboarded bench with a slot-list reference
// model, directed game scenarios and a randomized run.
module tb_letter_scheduler;

    localparam int SLOTS = 4;
    localparam int SP    = 3;
    localparam int XM    = 440;
    localparam int ML    = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                frame_tick = 1'b0;
    logic                start = 1'b0;
    logic [7:0]          gen_ch = '0;
    logic [2:0]          gen_speed = '0;
    logic [9:0]          gen_y = '0;
    logic                key_valid = 1'b0;
    logic [7:0]          key_ch = '0;
    logic [1:0]          state;
    logic [SLOTS-1:0]    slot_valid;
    logic [8*SLOTS-1:0]  slot_ch;
    logic [9*SLOTS-1:0]  slot_x;
    logic [10*SLOTS-1:0] slot_y;
    logic [3*SLOTS-1:0]  slot_spd;
    logic                hit_pulse;
    logic                miss_pulse;
    logic [15:0]         score;
    logic [7:0]          miss_cnt;

    letter_scheduler #(
        .SLOTS(SLOTS),
        .SPAWN_PERIOD(SP),
        .X_MAX(XM),
        .MISS_LIMIT(ML)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_tick(frame_tick),
        .start(start),
        .gen_ch(gen_ch),
        .gen_speed(gen_speed),
        .gen_y(gen_y),
        .key_valid(key_valid),
        .key_ch(key_ch),
        .state(state),
        .slot_valid(slot_valid),
        .slot_ch(slot_ch),
        .slot_x(slot_x),
        .slot_y(slot_y),
        .slot_spd(slot_spd),
        .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse),
        .score(score),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]          st;
        logic [SLOTS-1:0]    v;
        logic [8*SLOTS-1:0]  ch;
        logic [9*SLOTS-1:0]  x;
        logic [10*SLOTS-1:0] y;
        logic [3*SLOTS-1:0]  spd;
        logic                hit;
        logic                mp;
        logic [15:0]         score;
        logic [7:0]          mc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // reference game: a list of letters with plain integer positions
    int m_st, m_cnt, m_score, m_mc;
    bit m_v   [SLOTS];
    int m_ch  [SLOTS];
    int m_x   [SLOTS];
    int m_y   [SLOTS];
    int m_spd [SLOTS];
    bit m_hit, m_mp;

    logic [7:0] g_ch = 8'h41;
    logic [2:0] g_spd = 3'd2;
    logic [9:0] g_y = 10'd100;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_score = 0; m_mc = 0;
        m_hit = 0; m_mp = 0;
        for (int i = 0; i < SLOTS; i++) begin
            m_v[i] = 0; m_ch[i] = 0; m_x[i] = 0;
            m_y[i] = 0; m_spd[i] = 0;
        end
    endtask

    task automatic model_step(input bit ft, input bit st, input bit kv,
                              input int kc, input int gch, input int gsp,
                              input int gy);
        bit ov [SLOTS];
        int hi;
        int nm;
        int ns;
        bit spawn;
        m_hit = 0;
        m_mp  = 0;
        if (st) begin
            m_st = 1; m_score = 0; m_mc = 0; m_cnt = 0;
            for (int i = 0; i < SLOTS; i++) m_v[i] = 0;
            return;
        end
        if (m_st != 1) return;
        ns = (m_mc >= ML) ? 2 : 1;
        ov = m_v;
        hi = -1;
        if (kv)
            for (int i = 0; i < SLOTS; i++)
                if (ov[i] && m_ch[i] == kc && (hi < 0 || m_x[i] > m_x[hi]))
                    hi = i;
        if (hi >= 0) begin
            m_v[hi] = 0;
            m_hit   = 1;
            if (m_score < 65535) m_score++;
        end
        if (ft) begin
            spawn = (m_cnt == SP - 1);
            m_cnt = spawn ? 0 : m_cnt + 1;
            nm = 0;
            for (int i = 0; i < SLOTS; i++) begin
                if (ov[i] && i != hi) begin
                    if (m_x[i] + m_spd[i] >= XM) begin
                        m_v[i] = 0;
                        nm++;
                    end else begin
                        m_x[i] = m_x[i] + m_spd[i];
                    end
                end
            end
            if (nm > 0) begin
                m_mp = 1;
                m_mc = (m_mc + nm > 255) ? 255 : m_mc + nm;
            end
            if (spawn) begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (!ov[i]) begin
                        m_v[i] = 1; m_ch[i] = gch; m_x[i] = 0;
                        m_y[i] = gy; m_spd[i] = (gsp == 0) ? 1 : gsp;
                        break;
                    end
                end
            end
        end
        m_st = ns;
    endtask

    task automatic push_exp();
        exp_t e;
        e = '0;
        e.st    = 2'(m_st);
        e.hit   = m_hit;
        e.mp    = m_mp;
        e.score = 16'(m_score);
        e.mc    = 8'(m_mc);
        for (int i = 0; i < SLOTS; i++) begin
            e.v[i]           = m_v[i];
            e.ch[8*i +: 8]   = 8'(m_ch[i]);
            e.x[9*i +: 9]    = 9'(m_x[i]);
            e.y[10*i +: 10]  = 10'(m_y[i]);
            e.spd[3*i +: 3]  = 3'(m_spd[i]);
        end
        q.push_back(e);
    endtask

    task automatic step(input bit ft, input bit st, input bit kv,
                        input logic [7:0] kc);
        @(negedge clk);
        frame_tick = ft;
        start      = st;
        key_valid  = kv;
        key_ch     = kc;
        gen_ch     = g_ch;
        gen_speed  = g_spd;
        gen_y      = g_y;
        model_step(ft, st, kv, int'(kc), int'(g_ch), int'(g_spd), int'(g_y));
        push_exp();
    endtask

    task automatic tick();
        step(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic key(input logic [7:0] c);
        step(1'b0, 1'b0, 1'b1, c);
    endtask

    task automatic go();
        step(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_valid"}, 64'(slot_valid), 64'd0);
        check({tag, "_ch"}, 64'(slot_ch), 64'd0);
        check({tag, "_x"}, 64'(slot_x), 64'd0);
        check({tag, "_y"}, 64'(slot_y), 64'd0);
        check({tag, "_spd"}, 64'(slot_spd), 64'd0);
        check({tag, "_hit"}, 64'(hit_pulse), 64'd0);
        check({tag, "_miss"}, 64'(miss_pulse), 64'd0);
        check({tag, "_score"}, 64'(score), 64'd0);
        check({tag, "_misscnt"}, 64'(miss_cnt), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        frame_tick = 1'b0; start = 1'b0; key_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: compare every registered output against the queued model
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_state", 64'(state), 64'(e.st));
                check("sb_valid", 64'(slot_valid), 64'(e.v));
                check("sb_hit", 64'(hit_pulse), 64'(e.hit));
                check("sb_miss", 64'(miss_pulse), 64'(e.mp));
                check("sb_score", 64'(score), 64'(e.score));
                check("sb_misscnt", 64'(miss_cnt), 64'(e.mc));
                for (int i = 0; i < SLOTS; i++) begin
                    if (e.v[i]) begin
                        check($sformatf("sb_ch%0d", i),
                              64'(slot_ch[8*i +: 8]), 64'(e.ch[8*i +: 8]));
                        check($sformatf("sb_x%0d", i),
                              64'(slot_x[9*i +: 9]), 64'(e.x[9*i +: 9]));
                        check($sformatf("sb_y%0d", i),
                              64'(slot_y[10*i +: 10]), 64'(e.y[10*i +: 10]));
                        check($sformatf("sb_spd%0d", i),
                              64'(slot_spd[3*i +: 3]), 64'(e.spd[3*i +: 3]));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [7:0] kc;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ticks are ignored while idle
        tick(); tick();

        // first spawn on the third tick, then it starts to fall
        g_ch = 8'h41; g_spd = 3'd2; g_y = 10'd100;
        go();
        tick(); tick(); tick();
        settle();
        check("spawn_valid", 64'(slot_valid[0]), 64'd1);
        check("spawn_ch", 64'(slot_ch[7:0]), 64'h41);
        check("spawn_x", 64'(slot_x[8:0]), 64'd0);
        check("spawn_y", 64'(slot_y[9:0]), 64'd100);
        tick();
        settle();
        check("move_x", 64'(slot_x[8:0]), 64'd2);

        // fill the pool, drop one attempt, free slot 2 and refill it
        g_ch = 8'h42; tick(); tick();
        g_ch = 8'h43; tick(); tick(); tick();
        g_ch = 8'h44; tick(); tick(); tick();
        settle();
        check("full_valid", 64'(slot_valid), 64'hF);
        g_ch = 8'h58; tick(); tick(); tick();
        settle();
        check("drop_ch", 64'(slot_ch), 64'h44434241);
        key(8'h43);
        settle();
        check("free2_valid", 64'(slot_valid), 64'hB);
        g_ch = 8'h45; tick(); tick(); tick();
        settle();
        check("refill_valid", 64'(slot_valid), 64'hF);
        check("refill_ch", 64'(slot_ch[23:16]), 64'h45);

        // two matching letters: the lower one is hit; case is exact
        go();
        g_ch = 8'h42; g_spd = 3'd1; tick(); tick(); tick();
        g_spd = 3'd5; tick(); tick(); tick();
        g_ch = 8'h5A; g_spd = 3'd1;
        for (int i = 0; i < 6; i++) tick();
        key(8'h62);
        settle();
        check("lower_nohit", 64'(hit_pulse), 64'd0);
        key(8'h42);
        settle();
        check("pick_valid", 64'(slot_valid), 64'hD);
        check("pick_score", 64'(score), 64'd1);
        check("pick_pulse", 64'(hit_pulse), 64'd1);
        idle();
        settle();
        check("pulse_drop", 64'(hit_pulse), 64'd0);

        // key beats a miss in the same frame; a plain miss is counted
        go();
        g_ch = 8'h4D; g_spd = 3'd7; tick(); tick(); tick();
        g_ch = 8'h4E; tick(); tick(); tick();
        g_ch = 8'h51; g_spd = 3'd1;
        n = 0;
        while (m_x[0] + m_spd[0] < XM && n < 200) begin tick(); n++; end
        check("approach_bound", 64'(n < 200), 64'd1);
        step(1'b1, 1'b0, 1'b1, 8'h4D);
        settle();
        check("save_hit", 64'(hit_pulse), 64'd1);
        check("save_misscnt", 64'(miss_cnt), 64'd0);
        n = 0;
        while (m_v[1] && n < 200) begin tick(); n++; end
        check("miss_bound", 64'(n < 200), 64'd1);
        settle();
        check("miss_cnt1", 64'(miss_cnt), 64'd1);
        check("miss_pulse1", 64'(miss_pulse), 64'd1);

        // two letters miss on one tick and the game ends
        go();
        g_ch = 8'h50; g_spd = 3'd4; tick(); tick(); tick();
        g_ch = 8'h57; g_spd = 3'd1; tick(); tick(); tick();
        g_ch = 8'h58; tick(); tick(); tick();
        g_ch = 8'h59; tick(); tick(); tick();
        for (int i = 0; i < 24; i++) tick();
        key(8'h57);
        g_ch = 8'h52; g_spd = 3'd6; tick(); tick(); tick();
        g_ch = 8'h51; g_spd = 3'd1;
        n = 0;
        while (m_v[0] && n < 200) begin tick(); n++; end
        check("double_bound", 64'(n < 200), 64'd1);
        settle();
        check("double_valid", 64'(slot_valid[1:0]), 64'd0);
        check("double_cnt", 64'(miss_cnt), 64'd2);
        check("double_pulse", 64'(miss_pulse), 64'd1);
        check("double_state", 64'(state), 64'd1);
        idle();
        settle();
        check("over_state", 64'(state), 64'd2);
        check("over_pulse", 64'(miss_pulse), 64'd0);
        tick(); key(8'h59); tick();
        settle();
        check("frozen_valid", 64'(slot_valid), 64'hC);
        go();
        settle();
        check("restart_state", 64'(state), 64'd1);
        check("restart_valid", 64'(slot_valid), 64'd0);
        check("restart_cnt", 64'(miss_cnt), 64'd0);

        // asynchronous reset mid-game, then ticks are ignored
        g_ch = 8'h41; g_spd = 3'd3;
        for (int i = 0; i < 6; i++) tick();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        settle();
        check("post_rst_valid", 64'(slot_valid), 64'd0);
        check("post_rst_state", 64'(state), 64'd0);

        // randomized play against the reference model
        go();
        for (int i = 0; i < 3000; i++) begin
            g_ch  = 8'h41 + 8'($urandom_range(0, 3));
            g_spd = 3'($urandom_range(0, 7));
            g_y   = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0)
                kc = 8'h61 + 8'($urandom_range(0, 3));
            else
                kc = 8'h41 + 8'($urandom_range(0, 3));
            step($urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) == 0, kc);
        end
        @(posedge clk);
        #3;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
